// File: rtl/seg_scan.sv
// Time-multiplexed scan driver for a multi-digit 7-segment display.
// Holds a packed BCD value, scans one digit per slot with dead time, and updates only at frame boundaries.
module seg_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GAP    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic [3:0]            num,
  output logic [DIGITS-1:0]     dig_en
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_GAP  = CW'(GAP);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   disp;
  logic [4*DIGITS-1:0]   pend;
  logic                  pend_v;

  logic                  slot_end;
  logic                  frame_end;
  logic                  accept;
  logic [DIGITS-1:0]     upper_zero;
  logic [DIGITS-1:0]     blanked;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign in_ready  = ~pend_v;
  assign accept    = in_valid && ~pend_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // accept and frame_end never both touch pend_v: accept needs pend_v=0,
  // and the boundary only acts when pend_v=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp   <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
    end else begin
      if (frame_end && pend_v) begin
        disp   <= pend;
        pend_v <= 1'b0;
      end
      if (accept) begin
        pend   <= value;
        pend_v <= 1'b1;
      end
    end
  end

  always_comb begin
    num = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) num = disp[4*k +: 4];
    end
  end

  // upper_zero[k]: this digit and every more significant digit are zero.
  always_comb begin
    logic run_zero;
    run_zero   = 1'b1;
    upper_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run_zero      = run_zero && (disp[4*k +: 4] == 4'd0);
      upper_zero[k] = run_zero;
    end
  end

  always_comb begin
    blanked = '0;
    for (int k = 1; k < DIGITS; k++) begin
      blanked[k] = blank_lz && upper_zero[k];
    end
  end

  always_comb begin
    dig_en = '0;
    if (cnt >= CNT_GAP) begin
      for (int k = 0; k < DIGITS; k++) begin
        if ((idx == IW'(k)) && !blanked[k]) dig_en[k] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with DIGITS=4, DIV=8, GAP=2.
module tb_seg_scan;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  num;
  logic [3:0]  dig_en;

  int          npass;
  int          ntotal;
  int          cyc;
  logic [15:0] edisp;
  logic [15:0] epend;
  logic        epv;
  logic [3:0]  seen;

  seg_scan #(.DIGITS(4), .DIV(8), .GAP(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .value    (value),
    .blank_lz (blank_lz),
    .num      (num),
    .dig_en   (dig_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  function automatic logic [3:0] exp_en();
    int c;
    int i;
    logic [3:0] e;
    c = cyc % 8;
    i = (cyc / 8) % 4;
    e = 4'b0000;
    if (c >= 2) begin
      e = 4'b0001 << i;
      if (blank_lz && i >= 1 && ((edisp >> (4 * i)) == 16'h0000)) e = 4'b0000;
    end
    return e;
  endfunction

  function automatic logic [3:0] exp_num();
    int i;
    logic [15:0] s;
    i = (cyc / 8) % 4;
    s = edisp >> (4 * i);
    return s[3:0];
  endfunction

  task automatic tick();
    logic acc;
    logic bnd;
    logic [15:0] vcap;
    acc  = in_valid && !epv;
    bnd  = (cyc % 32) == 31;
    vcap = value;
    @(posedge clk);
    #1;
    if (bnd && epv) begin
      edisp = epend;
      epv   = 1'b0;
    end
    if (acc) begin
      epend = vcap;
      epv   = 1'b1;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) begin
      tick();
      chk("num", 32'(num), 32'(exp_num()));
      chk("dig_en", 32'(dig_en), 32'(exp_en()));
      chk("in_ready", 32'(in_ready), 32'(!epv));
      seen = seen | dig_en;
    end
  endtask

  task automatic run_to(input int target);
    run(target - cyc);
  endtask

  initial begin
    npass    = 0;
    ntotal   = 0;
    cyc      = 0;
    edisp    = 16'h0000;
    epend    = 16'h0000;
    epv      = 1'b0;
    seen     = 4'b0000;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;

    // Reset and idle scan of zeros
    #2 rst_n = 1'b0;
    #1;
    chk("rst_num", 32'(num), 32'h0);
    chk("rst_dig_en", 32'(dig_en), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    chk("start_dig_en", 32'(dig_en), 32'h0);
    run(40);
    chk("idle_in_ready", 32'(in_ready), 32'h1);

    // Load 1234; shown from the next frame start at cycle 64
    in_valid = 1'b1;
    value    = 16'h1234;
    run(1);
    in_valid = 1'b0;
    value    = 16'hdead;
    chk("acc_in_ready", 32'(in_ready), 32'h0);
    run_to(63);
    chk("pre_bnd_num", 32'(num), 32'h0);
    chk("pre_bnd_ready", 32'(in_ready), 32'h0);
    run(1);
    chk("bnd_ready", 32'(in_ready), 32'h1);
    chk("slot0_num", 32'(num), 32'h4);
    chk("slot0_gap", 32'(dig_en), 32'h0);
    run_to(66);
    chk("slot0_en", 32'(dig_en), 32'b0001);
    run_to(90);
    chk("slot3_num", 32'(num), 32'h1);
    chk("slot3_en", 32'(dig_en), 32'b1000);

    // Leading-zero blanking with 0070, then 0000
    run_to(96);
    blank_lz = 1'b1;
    in_valid = 1'b1;
    value    = 16'h0070;
    run(1);
    in_valid = 1'b0;
    run_to(128);
    seen = 4'b0000;
    run_to(160);
    chk("blank70_seen", 32'(seen), 32'b0011);
    run_to(136 + 32);
    in_valid = 1'b1;
    value    = 16'h0000;
    run(1);
    in_valid = 1'b0;
    run_to(192);
    seen = 4'b0000;
    run_to(204);
    chk("blank00_seen", 32'(seen), 32'b0001);
    chk("blank00_d1", 32'(dig_en), 32'b0000);
    blank_lz = 1'b0;
    #1;
    chk("unblank_d1", 32'(dig_en), 32'b0010);
    chk("unblank_num", 32'(num), 32'h0);
    run_to(224);

    // Back-to-back offers: 1111 then 2222, second stalls until the boundary
    in_valid = 1'b1;
    value    = 16'h1111;
    run(1);
    value    = 16'h2222;
    run_to(255);
    chk("b2b_stall", 32'(in_ready), 32'h0);
    chk("b2b_old_num", 32'(num), 32'h0);
    run(1);
    chk("b2b_ready", 32'(in_ready), 32'h1);
    chk("b2b_first", 32'(num), 32'h1);
    run(1);
    in_valid = 1'b0;
    chk("b2b_acc2", 32'(in_ready), 32'h0);
    run_to(287);
    chk("b2b_last1", 32'(num), 32'h1);
    run(1);
    chk("b2b_second", 32'(num), 32'h2);

    // Accept in the boundary cycle itself: shown one frame later
    run_to(319);
    in_valid = 1'b1;
    value    = 16'h9999;
    run(1);
    in_valid = 1'b0;
    chk("bacc_keep", 32'(num), 32'h2);
    chk("bacc_ready", 32'(in_ready), 32'h0);
    run_to(351);
    chk("bacc_still", 32'(num), 32'h2);
    run(1);
    chk("bacc_show", 32'(num), 32'h9);

    // Asynchronous reset mid-slot with 5555 pending
    run_to(360);
    in_valid = 1'b1;
    value    = 16'h5555;
    run(1);
    in_valid = 1'b0;
    run_to(363);
    chk("pre_rst_en", 32'(dig_en), 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("arst_num", 32'(num), 32'h0);
    chk("arst_dig_en", 32'(dig_en), 32'h0);
    chk("arst_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    edisp = 16'h0000;
    epend = 16'h0000;
    epv   = 1'b0;
    run(1);
    chk("restart_num", 32'(num), 32'h0);
    run(70);
    chk("post_rst_num", 32'(num), 32'h0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
